scr1_pipe_fprf_wb_sched: RTL and testbench
==========================================

# scr1_pipe_fprf_wb_sched

Writeback scheduler and scoreboard for the floating-point register file (FPRF). Arbitrates three result producers (LSU float loads, FPU, EXU integer-to-FP moves) onto the FPRF's single write port through one registered writeback stage. Tracks pending destination registers in a busy scoreboard. Raises RAW/WAW hazards toward the EXU issue logic. Sits between the EXU/FPU/LSU and the FPRF write interface.

## Interface
- `FPRF_AWIDTH`, default 5: FPRF address width.
- `XLEN`, default 32: data width.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `exu2sch_issue_vd_i` in 1: EXU requests to issue an FP-writing instruction.
- `exu2sch_issue_rd_i` in FPRF_AWIDTH: destination of the issuing instruction.
- `sch2exu_issue_stall_o` out 1: issue blocked by a hazard.
- `exu2sch_rs{1,2,3}_addr_i` in FPRF_AWIDTH: source addresses of the issuing instruction.
- `exu2sch_rs{1,2,3}_use_i` in 1: the corresponding source is actually read.
- `req{0,1,2}_vd_i` in 1: result valid (0 = LSU, 1 = FPU, 2 = EXU move).
- `req{0,1,2}_rd_i` in FPRF_AWIDTH: result destination.
- `req{0,1,2}_data_i` in XLEN: result data.
- `req{0,1,2}_rdy_o` out 1: result accepted this cycle.
- `sch2fprf_w_req_o` out 1: FPRF write enable.
- `sch2fprf_rd_addr_o` out FPRF_AWIDTH: FPRF write address.
- `sch2fprf_rd_data_o` out XLEN: FPRF write data.

## Operation
- **Scoreboard.**
  - `busy[2**FPRF_AWIDTH-1:0]` holds one bit per FPRF entry.
  - A bit is set on an accepted issue: `issue_vd_i & ~issue_stall_o`, at bit `issue_rd_i`.
  - A bit is cleared in the cycle the writeback stage presents its write: `w_req_o=1`, at bit `rd_addr_o`.
- **Hazard.** `issue_stall_o = issue_vd_i & (busy[issue_rd_i] | OR over k of (rs{k}_use_i & busy[rs{k}_addr_i]))`.
  - The output is combinational from current state only.
- **Arbitration.**
  - Round-robin over the three requesters using a 2-bit pointer `rr_ptr`, legal values 0..2.
  - The first valid requester at or after `rr_ptr` (mod 3) is granted, and its `rdy_o` is asserted combinationally in the same cycle.
  - At most one `rdy_o` is high per cycle.
  - On a grant, `rr_ptr` becomes (granted index + 1) mod 3. With no request, `rr_ptr` holds.
- **Handshake.**
  - A transfer occurs when `vd_i & rdy_o` are both high.
  - A requester holds `vd`, `rd` and `data` stable until the transfer.
  - An unaccepted requester may not withdraw its request.
- **Writeback stage.**
  - On a transfer, `rd` and `data` are registered into the stage and `w_req_o=1` the following cycle. Otherwise `w_req_o=0`.
  - `rd_addr_o` and `rd_data_o` hold their last value when `w_req_o=0`.
  - The stage accepts a transfer every cycle, so there is no back-pressure from the FPRF.
- **Simultaneous events.**
  - Issue and clear of the same register in one cycle: the issue still sees `busy=1` and stalls, because the clear takes effect at the clock edge.
  - Issue and clear of different registers in one cycle: both take effect.
- **Reset.** Synchronous; dominates every other update in the cycle.
  - `busy=0`, `rr_ptr=0`, `w_req_o=0`, `rd_addr_o=0`, `rd_data_o=0`.
  - Results in flight at reset are discarded.
  - `rdy_o` and `issue_stall_o` are combinational, so they follow the reset state (all busy bits 0).
- **Simulation assertions** (`SCR1_TRGT_SIMULATION`):
  - a transfer whose `rd` is not busy;
  - a valid requester dropping `vd` before acceptance;
  - X on `rd` or `data` at a transfer.

## Timing
- Accept to FPRF write: 1 cycle.
- The FPRF write completes at the end of the `w_req_o` cycle. `busy` clears at that same edge.
- A dependent instruction therefore issues, at the earliest, the cycle after `w_req_o`, and reads the new value. No bypass is provided.
- Issue to first possible write: depends on the producer.
- Throughput: one write per cycle.
- Worst-case wait for a continuously-valid requester: 2 cycles.

## Structure
- Shared package / `scr1_arch_types.svh`:
  - requester index constants (`SCR1_FPWB_REQ_LSU=0`, `_FPU=1`, `_EXU=2`);
  - `SCR1_FPWB_REQ_NUM=3`;
  - a result struct type `{rd, data}`.
- One sub-module is natural: `scr1_rr_arb3`, a combinational round-robin grant with a registered pointer.
- The scoreboard and writeback stage stay in the top module.
- Implementation size: about 180 lines.

## Test plan
- **Reset:** assert `rst` with all requests valid → `w_req_o=0`, all `rdy_o=0` after reset; busy empty, so an issue of rd=5 does not stall.
- **RAW:**
  - Issue rd=3, then a second issue with rs2=3 and `use=1` → `issue_stall_o=1`.
  - FPU writes rd=3 with data 0x3F800000 → `w_req_o=1`, `rd_addr_o=3` one cycle after accept; stall drops the following cycle.
- **WAW:** with rd=7 busy, issue rd=7 → stall. An unused `rs3=7` (`use=0`) alone causes no stall.
- **Round-robin:**
  - All three valid continuously, `rr_ptr=0` → grants LSU, FPU, EXU, LSU…
  - `w_req_o` stays high every cycle with matching `rd`/`data`.
- **Same-cycle clear/issue:**
  - While `w_req_o=1` for rd=9, issue rd=9 → stalled that cycle, accepted next cycle, busy[9]=1 again.
  - Issue rd=4 in the same cycle (rd=4 not busy) → accepted.
- **Reset mid-operation:** `rst` with busy={1,2} and a pending writeback → the next cycle shows `w_req_o=0`, busy=0, `rr_ptr=0`.

Source files
------------

// File: rtl/scr1_pipe_fprf_wb_sched_pkg.sv
// Shared types for the FPRF writeback scheduler:
// requester indices, result bundle and round-robin helper.
package scr1_pipe_fprf_wb_sched_pkg;

    localparam int SCR1_FPRF_AWIDTH   = 5;
    localparam int SCR1_XLEN          = 32;
    localparam int SCR1_FPWB_REQ_NUM  = 3;

    typedef enum logic [1:0] {
        SCR1_FPWB_REQ_LSU = 2'd0,
        SCR1_FPWB_REQ_FPU = 2'd1,
        SCR1_FPWB_REQ_EXU = 2'd2
    } type_scr1_fpwb_req_e;

    typedef struct packed {
        logic [SCR1_FPRF_AWIDTH-1:0] rd;
        logic [SCR1_XLEN-1:0]        data;
    } type_scr1_fpwb_res_s;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        nxt = 2'd0;
        unique case (1'b1)
            (idx == SCR1_FPWB_REQ_LSU): nxt = SCR1_FPWB_REQ_FPU;
            (idx == SCR1_FPWB_REQ_FPU): nxt = SCR1_FPWB_REQ_EXU;
            default:                    nxt = SCR1_FPWB_REQ_LSU;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/scr1_pipe_fprf_wb_sched_if.sv
// Issue, producer-result and FPRF-write signals of the
// writeback scheduler; slave is the scheduler side.
interface scr1_pipe_fprf_wb_sched_if #(
    parameter int FPRF_AWIDTH = 5,
    parameter int XLEN        = 32
);
    logic                   exu2sch_issue_vd_i;
    logic [FPRF_AWIDTH-1:0] exu2sch_issue_rd_i;
    logic                   sch2exu_issue_stall_o;
    logic [FPRF_AWIDTH-1:0] exu2sch_rs1_addr_i;
    logic [FPRF_AWIDTH-1:0] exu2sch_rs2_addr_i;
    logic [FPRF_AWIDTH-1:0] exu2sch_rs3_addr_i;
    logic                   exu2sch_rs1_use_i;
    logic                   exu2sch_rs2_use_i;
    logic                   exu2sch_rs3_use_i;
    logic                   req0_vd_i;
    logic                   req1_vd_i;
    logic                   req2_vd_i;
    logic [FPRF_AWIDTH-1:0] req0_rd_i;
    logic [FPRF_AWIDTH-1:0] req1_rd_i;
    logic [FPRF_AWIDTH-1:0] req2_rd_i;
    logic [XLEN-1:0]        req0_data_i;
    logic [XLEN-1:0]        req1_data_i;
    logic [XLEN-1:0]        req2_data_i;
    logic                   req0_rdy_o;
    logic                   req1_rdy_o;
    logic                   req2_rdy_o;
    logic                   sch2fprf_w_req_o;
    logic [FPRF_AWIDTH-1:0] sch2fprf_rd_addr_o;
    logic [XLEN-1:0]        sch2fprf_rd_data_o;

    modport master (
        output exu2sch_issue_vd_i, exu2sch_issue_rd_i,
        output exu2sch_rs1_addr_i, exu2sch_rs2_addr_i,
        output exu2sch_rs3_addr_i, exu2sch_rs1_use_i,
        output exu2sch_rs2_use_i, exu2sch_rs3_use_i,
        output req0_vd_i, req1_vd_i, req2_vd_i,
        output req0_rd_i, req1_rd_i, req2_rd_i,
        output req0_data_i, req1_data_i, req2_data_i,
        input  sch2exu_issue_stall_o,
        input  req0_rdy_o, req1_rdy_o, req2_rdy_o,
        input  sch2fprf_w_req_o, sch2fprf_rd_addr_o,
        input  sch2fprf_rd_data_o
    );

    modport slave (
        input  exu2sch_issue_vd_i, exu2sch_issue_rd_i,
        input  exu2sch_rs1_addr_i, exu2sch_rs2_addr_i,
        input  exu2sch_rs3_addr_i, exu2sch_rs1_use_i,
        input  exu2sch_rs2_use_i, exu2sch_rs3_use_i,
        input  req0_vd_i, req1_vd_i, req2_vd_i,
        input  req0_rd_i, req1_rd_i, req2_rd_i,
        input  req0_data_i, req1_data_i, req2_data_i,
        output sch2exu_issue_stall_o,
        output req0_rdy_o, req1_rdy_o, req2_rdy_o,
        output sch2fprf_w_req_o, sch2fprf_rd_addr_o,
        output sch2fprf_rd_data_o
    );

endinterface

// File: rtl/scr1_pipe_fprf_wb_sched_arb.sv
// Three-way round-robin arbiter: combinational grant,
// registered pointer to the requester after the last winner.
module scr1_pipe_fprf_wb_sched_arb
    import scr1_pipe_fprf_wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] vd,
    output logic [2:0] gnt,
    output logic [1:0] gnt_idx
);

    logic [1:0] rr_ptr;
    logic [1:0] idx;
    logic [3:0] vd_ext;
    logic [3:0] gnt_ext;
    logic       found;

    assign vd_ext = {1'b0, vd};
    assign gnt    = gnt_ext[2:0];

    // Nothing is granted while in reset so no result is lost.
    always_comb begin
        gnt_ext = '0;
        gnt_idx = rr_ptr;
        found   = 1'b0;
        idx     = rr_ptr;
        for (int i = 0; i < SCR1_FPWB_REQ_NUM; i++) begin
            if (!found && !rst && vd_ext[idx]) begin
                found        = 1'b1;
                gnt_ext[idx] = 1'b1;
                gnt_idx      = idx;
            end
            idx = rr_next(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (found) begin
            rr_ptr <= rr_next(gnt_idx);
        end
    end

endmodule

// File: rtl/scr1_pipe_fprf_wb_sched.sv
// FPRF writeback scheduler: busy scoreboard, issue hazard
// detection and one registered write stage fed by the arbiter.
module scr1_pipe_fprf_wb_sched
    import scr1_pipe_fprf_wb_sched_pkg::*;
#(
    parameter int FPRF_AWIDTH = SCR1_FPRF_AWIDTH,
    parameter int XLEN        = SCR1_XLEN
) (
    input logic clk,
    input logic rst,
    scr1_pipe_fprf_wb_sched_if.slave sch
);

    localparam int NREG = 2**FPRF_AWIDTH;

    logic [NREG-1:0]     busy;
    logic [NREG-1:0]     set_mask;
    logic [NREG-1:0]     clr_mask;
    logic                hazard;
    logic                stall;
    logic [2:0]          req_vd;
    logic [2:0]          gnt;
    logic [1:0]          gnt_idx;
    logic                xfer;
    type_scr1_fpwb_res_s req_res [SCR1_FPWB_REQ_NUM];
    type_scr1_fpwb_res_s res_sel;
    type_scr1_fpwb_res_s wb_res;
    logic                wb_vd;

    assign req_vd = {sch.req2_vd_i, sch.req1_vd_i, sch.req0_vd_i};

    assign req_res[SCR1_FPWB_REQ_LSU] = '{sch.req0_rd_i, sch.req0_data_i};
    assign req_res[SCR1_FPWB_REQ_FPU] = '{sch.req1_rd_i, sch.req1_data_i};
    assign req_res[SCR1_FPWB_REQ_EXU] = '{sch.req2_rd_i, sch.req2_data_i};

    scr1_pipe_fprf_wb_sched_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .vd      (req_vd),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign xfer           = |gnt;
    assign sch.req0_rdy_o = gnt[SCR1_FPWB_REQ_LSU];
    assign sch.req1_rdy_o = gnt[SCR1_FPWB_REQ_FPU];
    assign sch.req2_rdy_o = gnt[SCR1_FPWB_REQ_EXU];

    always_comb begin
        res_sel = req_res[SCR1_FPWB_REQ_LSU];
        unique case (1'b1)
            gnt[SCR1_FPWB_REQ_FPU]: res_sel = req_res[SCR1_FPWB_REQ_FPU];
            gnt[SCR1_FPWB_REQ_EXU]: res_sel = req_res[SCR1_FPWB_REQ_EXU];
            default:                res_sel = req_res[SCR1_FPWB_REQ_LSU];
        endcase
    end

    // A clear lands at the same edge as a set, so a same-reg issue still stalls.
    assign hazard = busy[sch.exu2sch_issue_rd_i]
                  | (sch.exu2sch_rs1_use_i & busy[sch.exu2sch_rs1_addr_i])
                  | (sch.exu2sch_rs2_use_i & busy[sch.exu2sch_rs2_addr_i])
                  | (sch.exu2sch_rs3_use_i & busy[sch.exu2sch_rs3_addr_i]);

    assign stall = sch.exu2sch_issue_vd_i & hazard;
    assign sch.sch2exu_issue_stall_o = stall;

    assign set_mask = (sch.exu2sch_issue_vd_i & ~stall)
                    ? (NREG'(1) << sch.exu2sch_issue_rd_i) : '0;
    assign clr_mask = wb_vd ? (NREG'(1) << wb_res.rd) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vd  <= 1'b0;
            wb_res <= '0;
        end else begin
            wb_vd <= xfer;
            if (xfer) begin
                wb_res <= res_sel;
            end
        end
    end

    assign sch.sch2fprf_w_req_o   = wb_vd;
    assign sch.sch2fprf_rd_addr_o = wb_res.rd;
    assign sch.sch2fprf_rd_data_o = wb_res.data;

`ifdef SCR1_TRGT_SIMULATION
    logic [2:0] pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= req_vd & ~gnt;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (xfer) begin
                assert (!$isunknown(res_sel))
                    else $error("fpwb: X on rd/data at transfer");
                assert (busy[res_sel.rd])
                    else $error("fpwb: transfer to non-busy rd");
            end
            assert ((pend_q & ~req_vd) == 3'b000)
                else $error("fpwb: request withdrawn");
        end
    end
`endif

endmodule

// File: tb/tb_scr1_pipe_fprf_wb_sched.sv
// Directed bench for the FPRF writeback scheduler: reset,
// RAW/WAW hazards, round-robin order, same-cycle clear/issue.
module tb_scr1_pipe_fprf_wb_sched;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    scr1_pipe_fprf_wb_sched_if #(
        .FPRF_AWIDTH (5),
        .XLEN        (32)
    ) sch ();

    scr1_pipe_fprf_wb_sched #(
        .FPRF_AWIDTH (5),
        .XLEN        (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sch (sch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic vd, input logic [4:0] rd,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rs3, input logic u3);
        sch.exu2sch_issue_vd_i = vd;
        sch.exu2sch_issue_rd_i = rd;
        sch.exu2sch_rs1_addr_i = 5'd0;
        sch.exu2sch_rs1_use_i  = 1'b0;
        sch.exu2sch_rs2_addr_i = rs2;
        sch.exu2sch_rs2_use_i  = u2;
        sch.exu2sch_rs3_addr_i = rs3;
        sch.exu2sch_rs3_use_i  = u3;
    endtask

    task automatic req(input int idx, input logic vd,
                       input logic [4:0] rd, input logic [31:0] d);
        case (idx)
            0: begin
                sch.req0_vd_i = vd; sch.req0_rd_i = rd; sch.req0_data_i = d;
            end
            1: begin
                sch.req1_vd_i = vd; sch.req1_rd_i = rd; sch.req1_data_i = d;
            end
            default: begin
                sch.req2_vd_i = vd; sch.req2_rd_i = rd; sch.req2_data_i = d;
            end
        endcase
    endtask

    function automatic logic [31:0] dval(input int rd);
        return 32'hC0DE_0000 + 32'(rd);
    endfunction

    function automatic logic [2:0] rdy_vec();
        return {sch.req2_rdy_o, sch.req1_rdy_o, sch.req0_rdy_o};
    endfunction

    initial begin
        rst = 1'b1;
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        req(0, 1'b1, 5'd1, 32'h11);
        req(1, 1'b1, 5'd2, 32'h22);
        req(2, 1'b1, 5'd3, 32'h33);
        tick();
        tick();
        chk("rst_wreq", 64'(sch.sch2fprf_w_req_o), 64'd0);

        rst = 1'b0;
        for (int i = 0; i < 3; i++) req(i, 1'b0, 5'd0, 32'd0);
        settle();
        chk("rst_rdy", 64'(rdy_vec()), 64'd0);
        chk("rst_addr", 64'(sch.sch2fprf_rd_addr_o), 64'd0);
        chk("rst_data", 64'(sch.sch2fprf_rd_data_o), 64'd0);
        chk("rst_busy", 64'(dut.busy), 64'd0);
        chk("rst_ptr", 64'(dut.u_arb.rr_ptr), 64'd0);
        issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("rst_issue5", 64'(sch.sch2exu_issue_stall_o), 64'd0);

        // RAW on rd=3
        issue(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd10, 5'd3, 1'b1, 5'd0, 1'b0);
        settle();
        chk("raw_stall", 64'(sch.sch2exu_issue_stall_o), 64'd1);
        req(1, 1'b1, 5'd3, 32'h3F80_0000);
        settle();
        chk("raw_rdy", 64'(rdy_vec()), 64'b010);
        tick();
        req(1, 1'b0, 5'd0, 32'd0);
        settle();
        chk("raw_wreq", 64'(sch.sch2fprf_w_req_o), 64'd1);
        chk("raw_addr", 64'(sch.sch2fprf_rd_addr_o), 64'd3);
        chk("raw_data", 64'(sch.sch2fprf_rd_data_o), 64'h3F80_0000);
        chk("raw_stall_wb", 64'(sch.sch2exu_issue_stall_o), 64'd1);
        tick();
        settle();
        chk("raw_release", 64'(sch.sch2exu_issue_stall_o), 64'd0);
        chk("raw_wreq_lo", 64'(sch.sch2fprf_w_req_o), 64'd0);
        chk("raw_addr_hold", 64'(sch.sch2fprf_rd_addr_o), 64'd3);
        tick();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("raw_busy10", 64'(dut.busy[10]), 64'd1);
        chk("raw_busy3", 64'(dut.busy[3]), 64'd0);

        // WAW on rd=7, unused source does not stall
        issue(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        settle();
        chk("waw_stall", 64'(sch.sch2exu_issue_stall_o), 64'd1);
        issue(1'b1, 5'd8, 5'd0, 1'b0, 5'd7, 1'b0);
        settle();
        chk("waw_unused", 64'(sch.sch2exu_issue_stall_o), 64'd0);
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Round-robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 1; r <= 6; r++) begin
            issue(1'b1, 5'(r), 5'd0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) req(i, 1'b1, 5'(i + 1), dval(i + 1));
        settle();
        for (int k = 0; k < 6; k++) begin
            int idx;
            logic [2:0] exp_g;
            idx   = k % 3;
            exp_g = 3'b001 << idx;
            chk($sformatf("rr_gnt%0d", k), 64'(rdy_vec()), 64'(exp_g));
            tick();
            if (k < 3) req(idx, 1'b1, 5'(idx + 4), dval(idx + 4));
            else       req(idx, 1'b0, 5'd0, 32'd0);
            settle();
            chk($sformatf("rr_wreq%0d", k),
                64'(sch.sch2fprf_w_req_o), 64'd1);
            chk($sformatf("rr_addr%0d", k),
                64'(sch.sch2fprf_rd_addr_o), 64'(k + 1));
            chk($sformatf("rr_data%0d", k),
                64'(sch.sch2fprf_rd_data_o), 64'(dval(k + 1)));
        end
        tick();
        settle();
        chk("rr_idle", 64'(sch.sch2fprf_w_req_o), 64'd0);

        // Same-cycle clear and issue of rd=9
        issue(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        req(1, 1'b1, 5'd9, 32'h99);
        settle();
        chk("sc_rdy_fpu", 64'(rdy_vec()), 64'b010);
        tick();
        req(1, 1'b0, 5'd0, 32'd0);
        issue(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("sc_wb9", 64'(sch.sch2fprf_rd_addr_o), 64'd9);
        chk("sc_stall9", 64'(sch.sch2exu_issue_stall_o), 64'd1);
        tick();
        settle();
        chk("sc_busy9_clr", 64'(dut.busy[9]), 64'd0);
        chk("sc_nostall9", 64'(sch.sch2exu_issue_stall_o), 64'd0);
        tick();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("sc_busy9_set", 64'(dut.busy[9]), 64'd1);

        // Clear rd=9 while issuing an unrelated rd=4
        req(0, 1'b1, 5'd9, 32'h9A);
        settle();
        chk("sc_rdy_lsu", 64'(rdy_vec()), 64'b001);
        tick();
        req(0, 1'b0, 5'd0, 32'd0);
        issue(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("sc_stall4", 64'(sch.sch2exu_issue_stall_o), 64'd0);
        tick();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("sc_busy4", 64'(dut.busy[4]), 64'd1);
        chk("sc_busy9_clr2", 64'(dut.busy[9]), 64'd0);

        // Reset with busy entries and a pending writeback
        issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        req(2, 1'b1, 5'd1, 32'h1234_5678);
        settle();
        chk("mr_rdy_exu", 64'(rdy_vec()), 64'b100);
        tick();
        req(2, 1'b0, 5'd0, 32'd0);
        settle();
        chk("mr_wreq", 64'(sch.sch2fprf_w_req_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("mr_wreq_lo", 64'(sch.sch2fprf_w_req_o), 64'd0);
        chk("mr_busy", 64'(dut.busy), 64'd0);
        chk("mr_ptr", 64'(dut.u_arb.rr_ptr), 64'd0);
        issue(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("mr_issue2", 64'(sch.sch2exu_issue_stall_o), 64'd0);
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
